// File: rtl/sr_latch_driver.sv
// sr_latch_driver: drives an external SR latch to a commanded value with a
// fixed-width S or R pulse, then waits for the synchronized latch outputs to
// confirm the new state (or flags an error after a bounded wait).
module sr_latch_driver #(
  parameter int unsigned PULSE_W = 4,
  parameter int unsigned TIMEOUT = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic cmd_valid,
  input  logic cmd_set,
  output logic cmd_ready,
  output logic S,
  output logic R,
  input  logic Q,
  input  logic Qbar,
  output logic state_q,
  output logic done,
  output logic err
);

  localparam int unsigned CntW = 8;
  localparam logic [CntW-1:0] PulseLast   = CntW'(PULSE_W - 1);
  localparam logic [CntW-1:0] TimeoutLast = CntW'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    StIdle,
    StPulse,
    StWait
  } fsm_e;

  fsm_e            fsm_q, fsm_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic            target_q, target_d;
  logic            s_q, s_d;
  logic            r_q, r_d;
  logic            done_q, done_d;
  logic            err_q, err_d;

  logic q_meta_q, q_sync_q;
  logic qb_meta_q, qb_sync_q;

  logic acc_match;
  logic wait_match;

  // Q/Qbar come from an asynchronous latch; only the second flop is ever used.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q_meta_q  <= 1'b0;
      q_sync_q  <= 1'b0;
      qb_meta_q <= 1'b0;
      qb_sync_q <= 1'b0;
    end else begin
      q_meta_q  <= Q;
      q_sync_q  <= q_meta_q;
      qb_meta_q <= Qbar;
      qb_sync_q <= qb_meta_q;
    end
  end

  // A match needs both rails consistent; Q == Qbar never matches.
  assign acc_match  = (q_sync_q == cmd_set) && (qb_sync_q == !cmd_set);
  assign wait_match = (q_sync_q == target_q) && (qb_sync_q == !target_q);

  // Next-state and registered-output logic for the command FSM.
  always_comb begin
    fsm_d    = fsm_q;
    cnt_d    = cnt_q;
    target_d = target_q;
    s_d      = 1'b0;
    r_d      = 1'b0;
    done_d   = 1'b0;
    err_d    = err_q;
    unique case (fsm_q)
      StIdle: begin
        if (cmd_valid) begin
          target_d = cmd_set;
          err_d    = 1'b0;
          cnt_d    = '0;
          if (acc_match) begin
            fsm_d = StWait;
          end else begin
            fsm_d = StPulse;
            s_d   = cmd_set;
            r_d   = !cmd_set;
          end
        end
      end
      StPulse: begin
        if (cnt_q == PulseLast) begin
          fsm_d = StWait;
          cnt_d = '0;
        end else begin
          cnt_d = cnt_q + 8'd1;
          s_d   = target_q;
          r_d   = !target_q;
        end
      end
      StWait: begin
        if (wait_match) begin
          done_d = 1'b1;
          fsm_d  = StIdle;
        end else if (cnt_q == TimeoutLast) begin
          err_d  = 1'b1;
          done_d = 1'b1;
          fsm_d  = StIdle;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      default: begin
        fsm_d = StIdle;
      end
    endcase
  end

  // State and output registers; reset abandons any command silently.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fsm_q    <= StIdle;
      cnt_q    <= '0;
      target_q <= 1'b0;
      s_q      <= 1'b0;
      r_q      <= 1'b0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      fsm_q    <= fsm_d;
      cnt_q    <= cnt_d;
      target_q <= target_d;
      s_q      <= s_d;
      r_q      <= r_d;
      done_q   <= done_d;
      err_q    <= err_d;
    end
  end

  assign cmd_ready = (fsm_q == StIdle);
  assign S         = s_q;
  assign R         = r_q;
  assign done      = done_q;
  assign err       = err_q;
  assign state_q   = q_sync_q;

endmodule
